// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/execute status and pipeline-control bundle for hazard_ctrl.
//   Pipeline side (master) drives: d_ra, d_rb, d_use_ra, d_use_rb, ex_rd, ex_rw,
//     ex_mrd, ex_hlt, ex_br_taken, intr.
//   Controller side (slave) drives: pc_ld, pc_sel, fd_ld, fd_flush, dex_ld,
//     dex_flush, intr_ack, halted, and fwd_a/fwd_b when FWD_EN is defined.
// Optional feature macro: FWD_EN (adds ALU-result forwarding selects).
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 2
);
    logic [REG_W-1:0] d_ra;
    logic [REG_W-1:0] d_rb;
    logic             d_use_ra;
    logic             d_use_rb;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rw;
    logic             ex_mrd;
    logic             ex_hlt;
    logic             ex_br_taken;
    logic             intr;

    logic             pc_ld;
    logic [1:0]       pc_sel;
    logic             fd_ld;
    logic             fd_flush;
    logic             dex_ld;
    logic             dex_flush;
    logic             intr_ack;
    logic             halted;
`ifdef FWD_EN
    logic             fwd_a;
    logic             fwd_b;
`endif

    modport master (
        output d_ra, d_rb, d_use_ra, d_use_rb, ex_rd, ex_rw, ex_mrd, ex_hlt,
               ex_br_taken, intr,
        input  pc_ld, pc_sel, fd_ld, fd_flush, dex_ld, dex_flush, intr_ack, halted
`ifdef FWD_EN
        , input fwd_a, fwd_b
`endif
    );

    modport slave (
        input  d_ra, d_rb, d_use_ra, d_use_rb, ex_rd, ex_rw, ex_mrd, ex_hlt,
               ex_br_taken, intr,
        output pc_ld, pc_sel, fd_ld, fd_flush, dex_ld, dex_flush, intr_ack, halted
`ifdef FWD_EN
        , output fwd_a, fwd_b
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller between the F/D and
// D/Ex latches. Handles load-use stalls, taken-branch flushes, halt, and
// interrupt entry (drain, then vector load).
//   clk   : clock
//   reset : asynchronous, active-low; forces every control output to 0
//   bus   : hazard_ctrl_if.slave (decode/ex status in, PC/latch controls out)
// Parameters: DRAIN_CYCLES (1..7) flush cycles before the vector load,
//             REG_W register index width.
// Optional feature macro: FWD_EN -- ALU results are forwarded (fwd_a/fwd_b),
// so only load-use stalls; without it any RAW on a register write stalls.
// Control outputs are combinational from state and current inputs.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned REG_W        = 2
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned CNT_W     = 3;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, HALT, DRAIN, VEC} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             intr_q;
    logic             pend, pend_n;

    logic [REG_W-1:0] ra, rb, rd;
    logic             raw_a, raw_b, haz;
    logic             intr_edge, pend_eff;

    logic       pc_ld, fd_ld, fd_flush, dex_ld, dex_flush, intr_ack, halted;
    logic [1:0] pc_sel;

    assign ra = bus.d_ra;
    assign rb = bus.d_rb;
    assign rd = bus.ex_rd;

    // Register-writing instruction in D/Ex whose destination is read in decode
    assign raw_a = bus.ex_rw && bus.d_use_ra && (ra == rd);
    assign raw_b = bus.ex_rw && bus.d_use_rb && (rb == rd);

`ifdef FWD_EN
    assign haz       = bus.ex_mrd && (raw_a || raw_b);
    assign bus.fwd_a = reset && !bus.ex_mrd && raw_a;
    assign bus.fwd_b = reset && !bus.ex_mrd && raw_b;
`else
    logic unused_mrd;
    assign unused_mrd = bus.ex_mrd;
    assign haz        = raw_a || raw_b;
`endif

    // An edge seen this cycle acts immediately; pend only remembers it
    assign intr_edge = bus.intr && !intr_q;
    assign pend_eff  = pend || intr_edge;

    // State, drain counter, interrupt edge detector and pending flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            cnt    <= '0;
            intr_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            intr_q <= bus.intr;
            pend   <= pend_n;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_n    = pend || intr_edge;
        pc_ld     = 1'b1;
        pc_sel    = 2'b00;
        fd_ld     = 1'b1;
        fd_flush  = 1'b0;
        dex_ld    = 1'b1;
        dex_flush = 1'b0;
        intr_ack  = 1'b0;
        halted    = 1'b0;

        unique case (state)
            RUN: begin
                if (bus.ex_hlt) begin
                    pc_ld     = 1'b0;
                    fd_ld     = 1'b0;
                    dex_flush = 1'b1;
                    state_n   = HALT;
                end else if (bus.ex_br_taken) begin
                    pc_sel    = 2'b01;
                    fd_flush  = 1'b1;
                    dex_flush = 1'b1;
                end else if (haz) begin
                    pc_ld     = 1'b0;
                    fd_ld     = 1'b0;
                    dex_flush = 1'b1;
                end else if (pend_eff) begin
                    pc_ld     = 1'b0;
                    fd_flush  = 1'b1;
                    dex_flush = 1'b1;
                    cnt_n     = DRAIN_LOAD;
                    state_n   = DRAIN;
                end
            end
            HALT: begin
                pc_ld     = 1'b0;
                fd_ld     = 1'b0;
                dex_ld    = 1'b0;
                dex_flush = 1'b1;
                if (pend_eff) begin
                    // Wake: halted drops in the same cycle the drain starts
                    fd_flush = 1'b1;
                    cnt_n    = DRAIN_LOAD;
                    state_n  = DRAIN;
                end else begin
                    halted = 1'b1;
                end
            end
            DRAIN: begin
                pc_ld     = 1'b0;
                fd_flush  = 1'b1;
                dex_flush = 1'b1;
                if (cnt == '0) begin
                    state_n = VEC;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            VEC: begin
                pc_sel    = 2'b10;
                fd_flush  = 1'b1;
                dex_flush = 1'b1;
                intr_ack  = 1'b1;
                pend_n    = 1'b0;
                state_n   = RUN;
            end
            default: begin
                state_n = RUN;
            end
        endcase

        // Nothing is enabled while the core is held in reset
        if (!reset) begin
            pc_ld     = 1'b0;
            pc_sel    = 2'b00;
            fd_ld     = 1'b0;
            fd_flush  = 1'b0;
            dex_ld    = 1'b0;
            dex_flush = 1'b0;
            intr_ack  = 1'b0;
            halted    = 1'b0;
        end
    end

    assign bus.pc_ld     = pc_ld;
    assign bus.pc_sel    = pc_sel;
    assign bus.fd_ld     = fd_ld;
    assign bus.fd_flush  = fd_flush;
    assign bus.dex_ld    = dex_ld;
    assign bus.dex_flush = dex_flush;
    assign bus.intr_ack  = intr_ack;
    assign bus.halted    = halted;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven RUN-state vectors plus directed sequences for
// interrupt entry, halt/wake, halt+interrupt in one cycle, and reset mid-drain.
module tb_hazard_ctrl;
    localparam int unsigned REG_W = 2;
    localparam int unsigned DRAIN = 2;

    // Packed outputs: {pc_ld, pc_sel[1:0], fd_ld, fd_flush, dex_ld, dex_flush, intr_ack, halted}
    localparam logic [8:0] O_ZERO  = 9'b0_00_0_0_0_0_0_0;
    localparam logic [8:0] O_RUN   = 9'b1_00_1_0_1_0_0_0;
    localparam logic [8:0] O_STALL = 9'b0_00_0_0_1_1_0_0;
    localparam logic [8:0] O_BR    = 9'b1_01_1_1_1_1_0_0;
    localparam logic [8:0] O_HLT   = 9'b0_00_0_0_1_1_0_0;
    localparam logic [8:0] O_DRAIN = 9'b0_00_1_1_1_1_0_0;
    localparam logic [8:0] O_VEC   = 9'b1_10_1_1_1_1_1_0;
    localparam logic [8:0] O_HALT  = 9'b0_00_0_0_0_1_0_1;
    localparam logic [8:0] O_WAKE  = 9'b0_00_0_1_0_1_0_0;
`ifdef FWD_EN
    localparam logic [8:0] O_ALU   = O_RUN;
`else
    localparam logic [8:0] O_ALU   = O_STALL;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    hazard_ctrl_if #(.REG_W(REG_W)) bus ();

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .REG_W(REG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic             ua;
        logic             ub;
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             mrd;
        logic             br;
        logic [8:0]       exp;
        logic [1:0]       fwd;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(string n, int ra, int rb, bit ua, bit ub, int rd,
                                bit rw, bit mrd, bit br, logic [8:0] exp, logic [1:0] fwd);
        vec_t v;
        v.name = n;
        v.ra   = REG_W'(ra);
        v.rb   = REG_W'(rb);
        v.ua   = ua;
        v.ub   = ub;
        v.rd   = REG_W'(rd);
        v.rw   = rw;
        v.mrd  = mrd;
        v.br   = br;
        v.exp  = exp;
        v.fwd  = fwd;
        return v;
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {bus.pc_ld, bus.pc_sel, bus.fd_ld, bus.fd_flush, bus.dex_ld,
               bus.dex_flush, bus.intr_ack, bus.halted};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pc_ld,pc_sel,fd_ld,fd_fl,dex_ld,dex_fl,ack,halted)",
                     name, got, exp);
        end
    endtask

    task automatic set_idle();
        bus.d_ra        = '0;
        bus.d_rb        = '0;
        bus.d_use_ra    = 1'b0;
        bus.d_use_rb    = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_rw       = 1'b0;
        bus.ex_mrd      = 1'b0;
        bus.ex_hlt      = 1'b0;
        bus.ex_br_taken = 1'b0;
    endtask

    // Advance to the next cycle's input-drive point
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = mk("idle",            0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'b00);
        vecs[1]  = mk("load_use_ra",     2, 0, 1, 0, 2, 1, 1, 0, O_STALL, 2'b00);
        vecs[2]  = mk("after_load_use",  0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'b00);
        vecs[3]  = mk("load_use_rb",     0, 3, 0, 1, 3, 1, 1, 0, O_STALL, 2'b00);
        vecs[4]  = mk("load_no_use",     2, 0, 0, 0, 2, 1, 1, 0, O_RUN,   2'b00);
        vecs[5]  = mk("load_idx_differ", 1, 3, 1, 1, 2, 1, 1, 0, O_RUN,   2'b00);
        vecs[6]  = mk("load_no_rw",      2, 0, 1, 0, 2, 0, 1, 0, O_RUN,   2'b00);
        vecs[7]  = mk("branch_and_haz",  2, 0, 1, 0, 2, 1, 1, 1, O_BR,    2'b00);
        vecs[8]  = mk("branch_only",     0, 0, 0, 0, 0, 0, 0, 1, O_BR,    2'b00);
        vecs[9]  = mk("alu_raw_rb",      0, 1, 0, 1, 1, 1, 0, 0, O_ALU,   2'b01);
        vecs[10] = mk("alu_raw_ra",      0, 2, 1, 0, 0, 1, 0, 0, O_ALU,   2'b10);
        vecs[11] = mk("alu_raw_unused",  3, 3, 0, 0, 3, 1, 0, 0, O_RUN,   2'b00);

        // Reset: outputs forced low even with a branch pending on the inputs
        reset = 1'b0;
        set_idle();
        bus.intr        = 1'b0;
        bus.ex_br_taken = 1'b1;
        #2;
        check("reset_outputs_zero", O_ZERO);
        repeat (2) @(posedge clk);
        next_cycle();
        bus.ex_br_taken = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_release_run", O_RUN);

        // Single-cycle RUN vectors
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            bus.d_ra        = vecs[i].ra;
            bus.d_rb        = vecs[i].rb;
            bus.d_use_ra    = vecs[i].ua;
            bus.d_use_rb    = vecs[i].ub;
            bus.ex_rd       = vecs[i].rd;
            bus.ex_rw       = vecs[i].rw;
            bus.ex_mrd      = vecs[i].mrd;
            bus.ex_br_taken = vecs[i].br;
            #1;
            check(vecs[i].name, vecs[i].exp);
`ifdef FWD_EN
            checks++;
            if ({bus.fwd_a, bus.fwd_b} !== vecs[i].fwd) begin
                errors++;
                $display("FAIL fwd_%s: got %b expected %b", vecs[i].name,
                         {bus.fwd_a, bus.fwd_b}, vecs[i].fwd);
            end
`endif
        end

        // Interrupt entry: RUN entry cycle, two drain cycles, vector, back to RUN
        next_cycle();
        set_idle();
        bus.intr = 1'b1;
        #1 check("intr_entry", O_DRAIN);
        next_cycle(); #1 check("intr_drain1", O_DRAIN);
        next_cycle(); #1 check("intr_drain2", O_DRAIN);
        next_cycle(); #1 check("intr_vec", O_VEC);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1 check("intr_held_no_ack", O_RUN);
        end
        next_cycle();
        bus.intr = 1'b0;
        #1 check("intr_low_run", O_RUN);

        // Halt, hold for 10 cycles, then wake on an interrupt edge
        next_cycle();
        bus.ex_hlt = 1'b1;
        #1 check("halt_enter", O_HLT);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            bus.ex_hlt = 1'b0;
            #1 check("halt_hold", O_HALT);
        end
        next_cycle();
        bus.intr = 1'b1;
        #1 check("halt_wake", O_WAKE);
        next_cycle(); #1 check("wake_drain1", O_DRAIN);
        next_cycle(); #1 check("wake_drain2", O_DRAIN);
        next_cycle(); #1 check("wake_vec", O_VEC);
        next_cycle(); #1 check("wake_run", O_RUN);
        next_cycle();
        bus.intr = 1'b0;
        #1 check("wake_intr_low", O_RUN);

        // Halt and interrupt edge in the same cycle: halt first, wake next cycle
        next_cycle();
        bus.ex_hlt = 1'b1;
        bus.intr   = 1'b1;
        #1 check("hlt_intr_same", O_HLT);
        next_cycle();
        bus.ex_hlt = 1'b0;
        #1 check("hlt_intr_wake", O_WAKE);
        next_cycle(); #1 check("hlt_intr_drain1", O_DRAIN);
        next_cycle(); #1 check("hlt_intr_drain2", O_DRAIN);
        next_cycle(); #1 check("hlt_intr_vec", O_VEC);
        next_cycle();
        bus.intr = 1'b0;
        #1 check("hlt_intr_run", O_RUN);

        // Reset in the middle of a drain aborts the interrupt
        next_cycle();
        bus.intr = 1'b1;
        #1 check("abort_entry", O_DRAIN);
        next_cycle(); #1 check("abort_drain1", O_DRAIN);
        #1;
        reset = 1'b0;
        #1 check("abort_reset_zero", O_ZERO);
        next_cycle();
        bus.intr = 1'b0;
        #1 check("abort_reset_hold", O_ZERO);
        next_cycle();
        reset = 1'b1;
        #1 check("abort_release_run", O_RUN);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); #1 check("abort_no_ack", O_RUN);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 8-bit pipelined core, sitting between the Fetch/Decode latch and the Decode/Execute latch.
- Consumes the decode-stage register indices and the D/Ex latch outputs (destination register, RW, memory-read, Hlt) plus the Ex-stage branch resolution.
- Drives the ld/flush controls of the PC, the F/D latch and the D/Ex latch.
- Sequences load-use stalls, branch flushes, halt and interrupt entry.

Parameters:
- DRAIN_CYCLES, 2, number of flush cycles inserted before the interrupt vector is loaded (1..7).
- REG_W, 2, register index width.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-low
- d_ra  input  REG_W  source A index of the instruction in decode
- d_rb  input  REG_W  source B index of the instruction in decode
- d_use_ra  input  1  decode instruction reads ra
- d_use_rb  input  1  decode instruction reads rb
- ex_rd  input  REG_W  destination index held in D/Ex
- ex_rw  input  1  D/Ex RW (instruction writes the register file)
- ex_mrd  input  1  D/Ex instruction is a memory load
- ex_hlt  input  1  D/Ex Hlt
- ex_br_taken  input  1  branch unit resolved taken this cycle
- intr  input  1  external interrupt request, level, synchronous to clk
- pc_ld  output  1  PC load enable
- pc_sel  output  2  00 PC+1, 01 branch target, 10 interrupt vector
- fd_ld  output  1  F/D latch load enable
- fd_flush  output  1  F/D latch flush
- dex_ld  output  1  D/Ex latch load enable
- dex_flush  output  1  D/Ex latch flush (bubble)
- intr_ack  output  1  one-cycle pulse when the vector is loaded
- halted  output  1  core is in HALT

Behaviour:
- States: RUN, HALT, DRAIN, VEC. Registered: state, drain counter (3-bit), intr_q (previous intr), pend.
- Reset low: state=RUN, counter=0, intr_q=0, pend=0. All outputs forced to 0 while reset is low, including pc_ld, fd_ld and dex_ld.
- Outputs are combinational from state and current inputs. Default in RUN: pc_ld=1, pc_sel=00, fd_ld=1, dex_ld=1, flushes=0.
- Interrupt edge: pend is set on intr=1 && intr_q=0. It is cleared only in VEC. A new edge while pend=1 is absorbed and not queued.
- Hazard term haz = ex_rw && ex_mrd && ((d_use_ra && d_ra==ex_rd) || (d_use_rb && d_rb==ex_rd)).
- RUN priority, highest first:
  1. ex_hlt: dex_flush=1, pc_ld=0, fd_ld=0; next state HALT.
  2. ex_br_taken: pc_sel=01, pc_ld=1, fd_flush=1, dex_flush=1; stay RUN.
  3. haz: pc_ld=0, fd_ld=0, dex_flush=1; stay RUN. Exactly one bubble per load-use.
  4. pend: pc_ld=0, fd_flush=1, dex_flush=1, counter=DRAIN_CYCLES-1; next state DRAIN.
- DRAIN: pc_ld=0, fd_flush=1, dex_flush=1. Counter decrements each cycle. When counter==0, next state is VEC.
- A branch arriving in DRAIN is ignored, since its instruction is already flushed.
- Interrupt entry from RUN takes DRAIN_CYCLES+1 cycles in total (including the RUN cycle of step 4) before VEC.
- VEC (1 cycle): pc_sel=10, pc_ld=1, fd_flush=1, dex_flush=1, intr_ack=1, pend cleared; next state RUN.
- HALT: halted=1, pc_ld=0, fd_ld=0, dex_ld=0, dex_flush=1.
  - Exit only via pend: goes to DRAIN with counter loaded to DRAIN_CYCLES-1, and halted drops in that same cycle.
  - Otherwise HALT holds until reset.
- An edge on intr in the same cycle as ex_hlt sets pend. HALT is entered and exits on the next cycle.
- Reset asserted mid-DRAIN/VEC aborts the sequence: pend=0, no intr_ack.

Optional Feature:
- FWD_EN defined: adds outputs fwd_a and fwd_b (1 bit each).
  - fwd_a = ex_rw && !ex_mrd && d_use_ra && d_ra==ex_rd; fwd_b likewise for rb.
  - ALU-result RAW is forwarded; only load-use stalls.
- FWD_EN undefined: no fwd ports. haz drops the ex_mrd term, so any ex_rw RAW match stalls one cycle.

Test Plan:
- Load-use: ex_rw=1, ex_mrd=1, ex_rd=2, d_use_ra=1, d_ra=2 for 1 cycle -> that cycle pc_ld=0, fd_ld=0, dex_flush=1; with the hazard removed, the next cycle returns to RUN defaults.
- Branch + hazard same cycle: ex_br_taken=1 and haz=1 -> pc_sel=01, pc_ld=1, fd_flush=1, dex_flush=1, no stall.
- Interrupt, DRAIN_CYCLES=2: intr rises at cycle 0 -> cycles 1–2 flush with pc_ld=0, cycle 3 pc_sel=10, intr_ack=1, cycle 4 RUN; intr held high causes no second ack.
- Halt then wake: ex_hlt=1 -> halted=1 next cycle, all ld=0 for 10 cycles; intr edge -> halted=0, VEC after 2 cycles, intr_ack pulses once.
- Reset mid-DRAIN: reset low during DRAIN -> all outputs 0 immediately; after release, RUN defaults with pend=0 and no intr_ack.
- FWD_EN: ex_rw=1, ex_mrd=0, ex_rd=1, d_rb=1, d_use_rb=1 -> with FWD_EN: fwd_b=1, no stall; without FWD_EN: one bubble.
